ps2_kbd_cmd_ctrl: RTL and testbench

PS2_KBD_CMD_CTRL -- requirements
Module: ps2_kbd_cmd_ctrl

---
 rtl/ps2_kbd_cmd_ctrl_if.sv | 26 ++
 rtl/ps2_kbd_cmd_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_kbd_cmd_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_cmd_ctrl_if.sv
// Bundle of keyboard-side, device-FIFO and status signals for ps2_kbd_cmd_ctrl.
// The slave modport is the controller; master is the surrounding environment.
interface ps2_kbd_cmd_ctrl_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic [7:0] dev_wdata;
  logic       dev_we;
  logic       dev_tx_empty;
  logic [8:0] dev_rdata;
  logic       dev_rd;
  logic [2:0] leds;
  logic       scan_en;
  logic [6:0] typematic;
  logic       busy;

  modport master (
    output key_valid, key_code, dev_tx_empty, dev_rdata,
    input  key_ready, dev_wdata, dev_we, dev_rd, leds, scan_en, typematic, busy
  );

  modport slave (
    input  key_valid, key_code, dev_tx_empty, dev_rdata,
    output key_ready, dev_wdata, dev_we, dev_rd, leds, scan_en, typematic, busy
  );
endinterface

// File: rtl/ps2_kbd_cmd_ctrl.sv
// Keyboard-side PS/2 command handler: decodes host bytes, streams replies,
// holds LED/scan/typematic state and forwards scancode bytes to the device FIFO.
module ps2_kbd_cmd_ctrl #(
  parameter logic [6:0] DEF_TYPEMATIC = 7'h2B
) (
  input logic               clk_sys,
  input logic               rst_n,
  ps2_kbd_cmd_ctrl_if.slave ifc
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP     = 2'd1,
    ARG_LED  = 2'd2,
    ARG_TYPE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          r_arg_pend;
  logic            r_dev_we;
  logic [7:0]      r_dev_wdata;
  logic            r_dev_rd;
  logic            r_dev_rd_d;
  logic            r_key_ready;
  logic [2:0]      r_leds;
  logic            r_scan_en;
  logic [6:0]      r_typematic;
  logic [1:0]      r_holdoff;
  logic [7:0]      r_last_tx;
  logic [2:0][7:0] r_rbuf;
  logic [1:0]      r_rcnt;
  logic [1:0]      r_ridx;
  logic            r_dly;
  logic [7:0]      r_key_buf;
  logic            r_key_buf_vld;

  logic       w_pend;
  logic [7:0] w_byte;
  logic       w_cmd_smp;
  logic       w_key_acc;
  logic       w_is_arg;
  logic [7:0] w_rsp0;
  logic [7:0] w_rsp1;
  logic [7:0] w_rsp2;
  logic [1:0] w_rsp_n;
  state_t     w_arg_nxt;
  logic       w_cfg_rst;
  logic       w_scan_wr;
  logic       w_scan_val;
  logic       w_type_def;
  logic       w_emit;
  logic [7:0] w_emit_byte;
  logic       w_resp_step;
  logic       w_buf_emit;
  logic       w_kr_next;

  assign w_pend    = ifc.dev_rdata[8];
  assign w_byte    = ifc.dev_rdata[7:0];
  // The two-cycle guard stops a pending flag that has not yet dropped from being re-read.
  assign w_cmd_smp = w_pend & ~r_dev_rd & ~r_dev_rd_d;
  assign w_key_acc = ifc.key_valid & r_key_ready;
  assign w_is_arg  = ((r_state == ARG_LED) || (r_state == ARG_TYPE)) && !w_byte[7];

  always_comb begin
    w_rsp0     = 8'hFA;
    w_rsp1     = 8'h00;
    w_rsp2     = 8'h00;
    w_rsp_n    = 2'd1;
    w_arg_nxt  = IDLE;
    w_cfg_rst  = 1'b0;
    w_scan_wr  = 1'b0;
    w_scan_val = 1'b0;
    w_type_def = 1'b0;
    if (!w_is_arg) begin
      case (w_byte)
        8'hFF: begin
          w_rsp1    = 8'hAA;
          w_rsp_n   = 2'd2;
          w_cfg_rst = 1'b1;
        end
        8'hF2: begin
          w_rsp1  = 8'hAB;
          w_rsp2  = 8'h83;
          w_rsp_n = 2'd3;
        end
        8'hEE: w_rsp0 = 8'hEE;
        8'hF4: begin
          w_scan_wr  = 1'b1;
          w_scan_val = 1'b1;
        end
        8'hF5: w_scan_wr = 1'b1;
        8'hF6: begin
          w_scan_wr  = 1'b1;
          w_scan_val = 1'b1;
          w_type_def = 1'b1;
        end
        8'hED:   w_arg_nxt = ARG_LED;
        8'hF3:   w_arg_nxt = ARG_TYPE;
        8'hFE:   w_rsp0 = r_last_tx;
        default: w_rsp0 = 8'hFE;
      endcase
    end
  end

  // Nothing is written while a host byte is pending; replies outrank held or live keys.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_byte = 8'h00;
    w_resp_step = 1'b0;
    w_buf_emit  = 1'b0;
    if (!w_pend) begin
      if ((r_state == RESP) && !r_dly) begin
        w_emit      = 1'b1;
        w_emit_byte = r_rbuf[r_ridx];
        w_resp_step = 1'b1;
      end else if ((r_state == IDLE) && r_key_buf_vld) begin
        w_emit      = 1'b1;
        w_emit_byte = r_key_buf;
        w_buf_emit  = 1'b1;
      end else if (w_key_acc) begin
        w_emit      = 1'b1;
        w_emit_byte = ifc.key_code;
      end
    end
  end

  assign w_kr_next = (r_state == IDLE) && r_scan_en && !w_pend && ifc.dev_tx_empty &&
                     !w_cmd_smp && (r_holdoff == 2'd0) && !w_key_acc && !r_key_buf_vld;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_arg_pend    <= IDLE;
      r_dev_we      <= 1'b0;
      r_dev_wdata   <= 8'h00;
      r_dev_rd      <= 1'b0;
      r_dev_rd_d    <= 1'b0;
      r_key_ready   <= 1'b0;
      r_leds        <= 3'd0;
      r_scan_en     <= 1'b1;
      r_typematic   <= DEF_TYPEMATIC;
      r_holdoff     <= 2'd0;
      r_last_tx     <= 8'hAA;
      r_rbuf        <= '0;
      r_rcnt        <= 2'd0;
      r_ridx        <= 2'd0;
      r_dly         <= 1'b0;
      r_key_buf     <= 8'h00;
      r_key_buf_vld <= 1'b0;
    end else begin
      r_dev_we    <= 1'b0;
      r_dev_rd    <= 1'b0;
      r_dev_rd_d  <= r_dev_rd;
      r_key_ready <= w_kr_next;

      // Holdoff covers the lag before dev_tx_empty reflects the byte just written.
      if (w_emit) begin
        r_dev_we    <= 1'b1;
        r_dev_wdata <= w_emit_byte;
        r_last_tx   <= w_emit_byte;
        r_holdoff   <= 2'd2;
      end else if (r_holdoff != 2'd0) begin
        r_holdoff <= r_holdoff - 2'd1;
      end

      if (w_buf_emit) begin
        r_key_buf_vld <= 1'b0;
      end
      if (w_key_acc && w_pend) begin
        r_key_buf     <= ifc.key_code;
        r_key_buf_vld <= 1'b1;
      end

      if (w_resp_step) begin
        r_ridx <= r_ridx + 2'd1;
        if (r_ridx == (r_rcnt - 2'd1)) begin
          r_state <= r_arg_pend;
        end
      end
      if ((r_state == RESP) && r_dly) begin
        r_dly <= 1'b0;
      end

      // A newly sampled host byte replaces any reply still in flight.
      if (w_cmd_smp) begin
        r_dev_rd   <= 1'b1;
        r_state    <= RESP;
        r_arg_pend <= w_arg_nxt;
        r_rbuf     <= {w_rsp2, w_rsp1, w_rsp0};
        r_rcnt     <= w_rsp_n;
        r_ridx     <= 2'd0;
        r_dly      <= 1'b1;
        if (w_is_arg) begin
          if (r_state == ARG_LED) begin
            r_leds <= w_byte[2:0];
          end else begin
            r_typematic <= w_byte[6:0];
          end
        end else begin
          if (w_cfg_rst) begin
            r_leds      <= 3'd0;
            r_scan_en   <= 1'b1;
            r_typematic <= DEF_TYPEMATIC;
          end
          if (w_scan_wr) begin
            r_scan_en <= w_scan_val;
          end
          if (w_type_def) begin
            r_typematic <= DEF_TYPEMATIC;
          end
        end
      end
    end
  end

  assign ifc.dev_we    = r_dev_we;
  assign ifc.dev_wdata = r_dev_wdata;
  assign ifc.dev_rd    = r_dev_rd;
  assign ifc.key_ready = r_key_ready;
  assign ifc.leds      = r_leds;
  assign ifc.scan_en   = r_scan_en;
  assign ifc.typematic = r_typematic;
  assign ifc.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Self-checking bench for ps2_kbd_cmd_ctrl: scoreboard of expected device
// writes plus per-scenario inline checks of timing and configuration outputs.
module tb_ps2_kbd_cmd_ctrl;
  logic clk_sys = 1'b0;
  logic rst_n;

  ps2_kbd_cmd_ctrl_if ifc ();

  ps2_kbd_cmd_ctrl #(.DEF_TYPEMATIC(7'h2B)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .ifc     (ifc)
  );

  always #5 clk_sys = ~clk_sys;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  // One clock: device clears pending after dev_rd, accepted keys are scored,
  // and every dev_we is popped against the scoreboard.
  task automatic tick();
    logic       pend_b;
    logic       rd_b;
    logic       acc_b;
    logic [7:0] code_b;
    logic [7:0] e;
    pend_b = ifc.dev_rdata[8];
    rd_b   = ifc.dev_rd;
    acc_b  = ifc.key_valid & ifc.key_ready;
    code_b = ifc.key_code;
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (rd_b) ifc.dev_rdata[8] = 1'b0;
    if (acc_b) begin
      exp_q.push_back(code_b);
      ifc.key_valid = 1'b0;
    end
    if (pend_b) begin
      n_vec++;
      if (ifc.dev_we !== 1'b0) begin
        n_err++;
        $display("FAIL we_while_pending: dev_we=%b required 0", ifc.dev_we);
      end
    end
    if (ifc.dev_we === 1'b1) begin
      n_vec++;
      $display("write %02h", ifc.dev_wdata);
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got %02h required none", ifc.dev_wdata);
      end else begin
        e = exp_q.pop_front();
        if (ifc.dev_wdata !== e) begin
          n_err++;
          $display("FAIL write_data: got %02h required %02h", ifc.dev_wdata, e);
        end
      end
    end
  endtask

  task automatic host_send(input logic [7:0] b);
    int k;
    ifc.dev_rdata = {1'b1, b};
    k = 0;
    while (ifc.dev_rdata[8] === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (ifc.dev_rdata[8] === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL host_rd_timeout: byte %02h never read, required dev_rd", b);
      ifc.dev_rdata = 9'h000;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.key_valid = 1'b0;
    ifc.key_code = 8'h00;
    ifc.dev_tx_empty = 1'b1;
    ifc.dev_rdata = 9'h000;
    repeat (2) @(negedge clk_sys);
    n_vec++; if (ifc.dev_we !== 1'b0) begin n_err++; $display("FAIL rst_dev_we: got %b required 0", ifc.dev_we); end
    n_vec++; if (ifc.dev_wdata !== 8'h00) begin n_err++; $display("FAIL rst_dev_wdata: got %02h required 00", ifc.dev_wdata); end
    n_vec++; if (ifc.dev_rd !== 1'b0) begin n_err++; $display("FAIL rst_dev_rd: got %b required 0", ifc.dev_rd); end
    n_vec++; if (ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL rst_key_ready: got %b required 0", ifc.key_ready); end
    n_vec++; if (ifc.leds !== 3'd0) begin n_err++; $display("FAIL rst_leds: got %0d required 0", ifc.leds); end
    n_vec++; if (ifc.scan_en !== 1'b1) begin n_err++; $display("FAIL rst_scan_en: got %b required 1", ifc.scan_en); end
    n_vec++; if (ifc.typematic !== 7'h2B) begin n_err++; $display("FAIL rst_typematic: got %02h required 2b", ifc.typematic); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", ifc.busy); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_vec++; if (ifc.key_ready !== 1'b1) begin n_err++; $display("FAIL idle_key_ready: got %b required 1", ifc.key_ready); end
    exp_q.push_back(8'hAA);
    host_send(8'hFE);
    drain();
  endtask

  task automatic test_misc_cmds();
    exp_q.push_back(8'hEE);
    host_send(8'hEE);
    drain();
    exp_q.push_back(8'hFE);
    host_send(8'h12);
    drain();
  endtask

  task automatic test_led();
    exp_q.push_back(8'hFA);
    host_send(8'hED);
    drain();
    n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL led_busy_between: got %b required 1", ifc.busy); end
    n_vec++; if (ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL led_key_ready_arg: got %b required 0", ifc.key_ready); end
    n_vec++; if (ifc.leds !== 3'd0) begin n_err++; $display("FAIL led_early: got %0d required 0", ifc.leds); end
    exp_q.push_back(8'hFA);
    host_send(8'h07);
    drain();
    n_vec++; if (ifc.leds !== 3'd7) begin n_err++; $display("FAIL led_value: got %0d required 7", ifc.leds); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL led_busy_after: got %b required 0", ifc.busy); end
  endtask

  task automatic test_led_preempt();
    exp_q.push_back(8'hFA);
    host_send(8'hED);
    drain();
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'h83);
    host_send(8'hF2);
    drain();
    n_vec++; if (ifc.leds !== 3'd7) begin n_err++; $display("FAIL preempt_leds: got %0d required 7", ifc.leds); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL preempt_busy: got %b required 0", ifc.busy); end
  endtask

  task automatic test_typematic();
    exp_q.push_back(8'hFA);
    host_send(8'hF3);
    drain();
    exp_q.push_back(8'hFA);
    host_send(8'h20);
    drain();
    n_vec++; if (ifc.typematic !== 7'h20) begin n_err++; $display("FAIL type_value: got %02h required 20", ifc.typematic); end
    exp_q.push_back(8'hFA);
    host_send(8'hF6);
    drain();
    n_vec++; if (ifc.typematic !== 7'h2B) begin n_err++; $display("FAIL type_default: got %02h required 2b", ifc.typematic); end
    exp_q.push_back(8'hFA);
    host_send(8'hF3);
    drain();
    exp_q.push_back(8'hFA);
    host_send(8'h35);
    drain();
  endtask

  task automatic test_reset_cmd();
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'hAA);
    ifc.dev_rdata = {1'b1, 8'hFF};
    tick();
    n_vec++; if (ifc.dev_rd !== 1'b1) begin n_err++; $display("FAIL ff_dev_rd: got %b required 1", ifc.dev_rd); end
    n_vec++; if (ifc.leds !== 3'd0) begin n_err++; $display("FAIL ff_leds: got %0d required 0", ifc.leds); end
    n_vec++; if (ifc.typematic !== 7'h2B) begin n_err++; $display("FAIL ff_typematic: got %02h required 2b", ifc.typematic); end
    n_vec++; if (ifc.scan_en !== 1'b1) begin n_err++; $display("FAIL ff_scan_en: got %b required 1", ifc.scan_en); end
    tick();
    n_vec++; if (ifc.dev_rd !== 1'b0 || ifc.dev_we !== 1'b0) begin n_err++; $display("FAIL ff_gap: rd=%b we=%b required 0 0", ifc.dev_rd, ifc.dev_we); end
    tick();
    n_vec++; if (ifc.dev_we !== 1'b1) begin n_err++; $display("FAIL ff_first_we: got %b required 1", ifc.dev_we); end
    tick();
    n_vec++; if (ifc.dev_we !== 1'b1) begin n_err++; $display("FAIL ff_second_we: got %b required 1", ifc.dev_we); end
    tick();
    n_vec++; if (ifc.dev_we !== 1'b0 || ifc.busy !== 1'b0) begin n_err++; $display("FAIL ff_end: we=%b busy=%b required 0 0", ifc.dev_we, ifc.busy); end
    drain();
  endtask

  task automatic test_scan_gate();
    int k;
    exp_q.push_back(8'hFA);
    host_send(8'hF5);
    drain();
    n_vec++; if (ifc.scan_en !== 1'b0) begin n_err++; $display("FAIL scan_off: got %b required 0", ifc.scan_en); end
    ifc.key_code = 8'h1C;
    ifc.key_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++; if (ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL scan_off_key_ready: got %b required 0", ifc.key_ready); end
    end
    exp_q.push_back(8'hFA);
    host_send(8'hF4);
    k = 0;
    while (ifc.key_valid === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (ifc.key_valid === 1'b1) begin
      n_err++;
      $display("FAIL key_accept_timeout: key_valid=%b required accepted", ifc.key_valid);
      ifc.key_valid = 1'b0;
    end else begin
      n_vec++; if (ifc.dev_we !== 1'b1 || ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL key_we: we=%b ready=%b required 1 0", ifc.dev_we, ifc.key_ready); end
      tick();
      n_vec++; if (ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL holdoff_1: got %b required 0", ifc.key_ready); end
      tick();
      n_vec++; if (ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL holdoff_2: got %b required 0", ifc.key_ready); end
      tick();
      n_vec++; if (ifc.key_ready !== 1'b1) begin n_err++; $display("FAIL holdoff_end: got %b required 1", ifc.key_ready); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int k;
    exp_q.push_back(8'hFA);
    ifc.dev_rdata = {1'b1, 8'hF2};
    k = 0;
    tick();
    while (ifc.dev_we !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    n_vec++;
    if (ifc.dev_we !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_timeout: dev_we=%b required 1", ifc.dev_we);
    end
    exp_q.push_back(8'hEE);
    host_send(8'hEE);
    drain();
  endtask

  task automatic test_resend();
    int k;
    ifc.key_code = 8'h1C;
    ifc.key_valid = 1'b1;
    k = 0;
    while (ifc.key_valid === 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_vec++;
    if (ifc.key_valid === 1'b1) begin
      n_err++;
      $display("FAIL resend_key_timeout: key_valid=%b required accepted", ifc.key_valid);
      ifc.key_valid = 1'b0;
    end
    drain();
    exp_q.push_back(8'h1C);
    host_send(8'hFE);
    drain();
  endtask

  task automatic test_reset_mid();
    int k;
    exp_q.push_back(8'hFA);
    host_send(8'hED);
    drain();
    exp_q.push_back(8'hFA);
    host_send(8'h05);
    drain();
    exp_q.push_back(8'hFA);
    ifc.dev_rdata = {1'b1, 8'hF2};
    k = 0;
    tick();
    while (ifc.dev_we !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    rst_n = 1'b0;
    ifc.dev_rdata = 9'h000;
    exp_q.delete();
    #1;
    n_vec++; if (ifc.dev_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %b required 0", ifc.dev_we); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b required 0", ifc.busy); end
    n_vec++; if (ifc.leds !== 3'd0) begin n_err++; $display("FAIL midrst_leds: got %0d required 0", ifc.leds); end
    n_vec++; if (ifc.typematic !== 7'h2B) begin n_err++; $display("FAIL midrst_type: got %02h required 2b", ifc.typematic); end
    n_vec++; if (ifc.scan_en !== 1'b1) begin n_err++; $display("FAIL midrst_scan: got %b required 1", ifc.scan_en); end
    n_vec++; if (ifc.key_ready !== 1'b0) begin n_err++; $display("FAIL midrst_key_ready: got %b required 0", ifc.key_ready); end
    @(negedge clk_sys);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    exp_q.push_back(8'hAA);
    host_send(8'hFE);
    drain();
  endtask

  initial begin
    test_reset();
    test_misc_cmds();
    test_led();
    test_led_preempt();
    test_typematic();
    test_reset_cmd();
    test_scan_gate();
    test_back_to_back();
    test_resend();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expect: %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
